// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle RV32 sequencing controller.
// The TRAP state is only reachable when MULTICYCLE_ILLEGAL_TRAP_EN is defined.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_TRAP   = 4'd9
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  function automatic logic is_known_op(input logic [6:0] op_v);
    return (op_v == OP_LW) || (op_v == OP_SW) || (op_v == OP_R) || (op_v == OP_BEQ);
  endfunction

endpackage

// File: rtl/mc_alu_op_decode.sv
// Combinational ALU-operation decoder for R-type instructions, consumed in EXECR.
module mc_alu_op_decode
  import multicycle_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  input  logic       i_op_5,
  output logic [2:0] o_alu_control
);

  // funct3 selects the operation; funct7[5] distinguishes sub from add
  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_funct3)
      3'b000:  o_alu_control = ({i_op_5, i_funct7_5} == 2'b11) ? ALU_SUB : ALU_ADD;
      3'b010:  o_alu_control = ALU_SLT;
      3'b110:  o_alu_control = ALU_OR;
      3'b111:  o_alu_control = ALU_AND;
      3'b100:  o_alu_control = ALU_XOR;
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing controller for the multi-cycle RV32 core (shared ALU, unified memory).
// Define MULTICYCLE_ILLEGAL_TRAP_EN to trap unknown opcodes and expose the sticky `illegal` port.
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_write,
  output logic               adr_src,
  output logic               ir_write,
  output logic               pc_write,
  output logic               reg_write,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         imm_src,
  output logic [2:0]         alu_control,
  output logic [1:0]         result_src,
  output logic               retire,
  output logic [STATE_W-1:0] state_o
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  ,
  output logic               illegal
`endif
);

  state_e     r_state;
  state_e     w_next;
  logic [2:0] w_dec_alu;
  logic       w_mem_req, w_mem_write, w_adr_src, w_ir_write, w_pc_write, w_reg_write, w_retire;
  logic [1:0] w_alu_src_a, w_alu_src_b, w_imm_src, w_result_src;
  logic [2:0] w_alu_control;
  logic       w_unused;

  assign w_unused = &{1'b0, funct7[6], funct7[4:0]};

  mc_alu_op_decode u_alu_dec (
    .i_funct3      (funct3),
    .i_funct7_5    (funct7[5]),
    .i_op_5        (op[5]),
    .o_alu_control (w_dec_alu)
  );

  // Next-state selection; FETCH/MEMRD/MEMWR hold until memory completes
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_BEQ:       w_next = S_BEQ;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          default:      w_next = S_TRAP;
`else
          default:      w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: w_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECR:  w_next = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BEQ: w_next = S_FETCH;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_TRAP:   w_next = S_TRAP;
`endif
      default:  w_next = S_FETCH;
    endcase
  end

  // State register; the illegal flag is sticky until reset
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= r_illegal | (w_next == S_TRAP);
    end
  end

  assign illegal = r_illegal & ~rst;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end
`endif

  // Per-state control decode; TRAP and any stray encoding leave everything at 0
  always_comb begin
    w_mem_req     = 1'b0;
    w_mem_write   = 1'b0;
    w_adr_src     = 1'b0;
    w_ir_write    = 1'b0;
    w_pc_write    = 1'b0;
    w_reg_write   = 1'b0;
    w_retire      = 1'b0;
    w_alu_src_a   = SRCA_PC;
    w_alu_src_b   = SRCB_REGB;
    w_imm_src     = IMM_I;
    w_alu_control = ALU_ADD;
    w_result_src  = RES_ALUOUT;
    case (r_state)
      S_FETCH: begin
        w_mem_req    = 1'b1;
        w_alu_src_b  = SRCB_FOUR;
        w_result_src = RES_ALURESULT;
        w_ir_write   = mem_ready;
        w_pc_write   = mem_ready;
      end
      S_DECODE: begin
        w_alu_src_a = SRCA_OLDPC;
        w_alu_src_b = SRCB_IMM;
        w_imm_src   = IMM_B;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        w_retire    = 1'b0;
`else
        w_retire    = ~is_known_op(op);
`endif
      end
      S_MEMADR: begin
        w_alu_src_a = SRCA_REGA;
        w_alu_src_b = SRCB_IMM;
        w_imm_src   = (op == OP_SW) ? IMM_S : IMM_I;
      end
      S_MEMRD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
      end
      S_MEMWB: begin
        w_result_src = RES_DATA;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
      end
      S_MEMWR: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        w_adr_src   = 1'b1;
        w_retire    = mem_ready;
      end
      S_EXECR: begin
        w_alu_src_a   = SRCA_REGA;
        w_alu_src_b   = SRCB_REGB;
        w_alu_control = w_dec_alu;
      end
      S_ALUWB: begin
        w_result_src = RES_ALUOUT;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
      end
      S_BEQ: begin
        w_alu_src_a   = SRCA_REGA;
        w_alu_src_b   = SRCB_REGB;
        w_alu_control = ALU_SUB;
        w_result_src  = RES_ALUOUT;
        w_pc_write    = zero;
        w_retire      = 1'b1;
      end
      default: begin
        w_retire = 1'b0;
      end
    endcase
  end

  // Reset overrides every output in the same cycle so an aborted access never strobes
  assign mem_req     = w_mem_req   & ~rst;
  assign mem_write   = w_mem_write & ~rst;
  assign adr_src     = w_adr_src   & ~rst;
  assign ir_write    = w_ir_write  & ~rst;
  assign pc_write    = w_pc_write  & ~rst;
  assign reg_write   = w_reg_write & ~rst;
  assign retire      = w_retire    & ~rst;
  assign alu_src_a   = rst ? 2'b00 : w_alu_src_a;
  assign alu_src_b   = rst ? 2'b00 : w_alu_src_b;
  assign imm_src     = rst ? 2'b00 : w_imm_src;
  assign alu_control = rst ? 3'b000 : w_alu_control;
  assign result_src  = rst ? 2'b00 : w_result_src;
  assign state_o     = rst ? '0 : STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller; honours MULTICYCLE_ILLEGAL_TRAP_EN when defined.
module tb_multicycle_controller;
  import multicycle_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, retire;
  logic [1:0] alu_src_a, alu_src_b, imm_src, result_src;
  logic [2:0] alu_control;
  logic [3:0] state_o;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  int n_vec = 0;
  int n_err = 0;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .alu_control(alu_control), .result_src(result_src), .retire(retire), .state_o(state_o)
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  // Control word: {req,wr,adr,irw,pcw,rw, srcA, srcB, imm, alu, res, retire}
  logic [17:0] w_cw;
  assign w_cw = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                 alu_src_a, alu_src_b, imm_src, alu_control, result_src, retire};

  localparam logic [17:0] CW_ZERO    = 18'd0;
  localparam logic [17:0] CW_FETCH_R = {6'b100110, 2'b00, 2'b10, 2'b00, 3'b000, 2'b10, 1'b0};
  localparam logic [17:0] CW_FETCH_W = {6'b100000, 2'b00, 2'b10, 2'b00, 3'b000, 2'b10, 1'b0};
  localparam logic [17:0] CW_DEC     = {6'b000000, 2'b01, 2'b01, 2'b10, 3'b000, 2'b00, 1'b0};
  localparam logic [17:0] CW_DEC_UNK = {6'b000000, 2'b01, 2'b01, 2'b10, 3'b000, 2'b00, 1'b1};
  localparam logic [17:0] CW_ADR_LW  = {6'b000000, 2'b10, 2'b01, 2'b00, 3'b000, 2'b00, 1'b0};
  localparam logic [17:0] CW_ADR_SW  = {6'b000000, 2'b10, 2'b01, 2'b01, 3'b000, 2'b00, 1'b0};
  localparam logic [17:0] CW_RD      = {6'b101000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0};
  localparam logic [17:0] CW_MWB     = {6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b1};
  localparam logic [17:0] CW_WR_W    = {6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0};
  localparam logic [17:0] CW_WR_R    = {6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1};
  localparam logic [17:0] CW_AWB     = {6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then check state and controls
  task automatic ex(input string tag, input logic r, input logic [6:0] o, input logic [2:0] f3,
                    input logic [6:0] f7, input logic zr, input logic rdy,
                    input state_e st, input logic [17:0] cw);
    @(negedge clk);
    rst = r; op = o; funct3 = f3; funct7 = f7; zero = zr; mem_ready = rdy;
    #1;
    chk({tag, ".state"}, 32'(state_o), 32'(st));
    chk({tag, ".ctl"}, 32'(w_cw), 32'(cw));
  endtask

  task automatic run_lw(input string t);
    ex({t, ".F"},  1'b0, OP_LW, 3'b010, 7'd0, 1'b0, 1'b1, S_FETCH,  CW_FETCH_R);
    ex({t, ".D"},  1'b0, OP_LW, 3'b010, 7'd0, 1'b0, 1'b0, S_DECODE, CW_DEC);
    ex({t, ".MA"}, 1'b0, OP_LW, 3'b010, 7'd0, 1'b0, 1'b0, S_MEMADR, CW_ADR_LW);
    ex({t, ".MR"}, 1'b0, OP_LW, 3'b010, 7'd0, 1'b0, 1'b1, S_MEMRD,  CW_RD);
    ex({t, ".WB"}, 1'b0, OP_LW, 3'b010, 7'd0, 1'b0, 1'b1, S_MEMWB,  CW_MWB);
  endtask

  task automatic run_r(input string t, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [2:0] alu);
    ex({t, ".F"},  1'b0, OP_R, f3, f7, 1'b0, 1'b1, S_FETCH,  CW_FETCH_R);
    ex({t, ".D"},  1'b0, OP_R, f3, f7, 1'b0, 1'b1, S_DECODE, CW_DEC);
    ex({t, ".EX"}, 1'b0, OP_R, f3, f7, 1'b0, 1'b1, S_EXECR,
       {6'b000000, 2'b10, 2'b00, 2'b00, alu, 2'b00, 1'b0});
    ex({t, ".WB"}, 1'b0, OP_R, f3, f7, 1'b0, 1'b1, S_ALUWB,  CW_AWB);
  endtask

  task automatic run_beq(input string t, input logic zr);
    ex({t, ".F"},  1'b0, OP_BEQ, 3'b000, 7'd0, zr, 1'b1, S_FETCH,  CW_FETCH_R);
    ex({t, ".D"},  1'b0, OP_BEQ, 3'b000, 7'd0, zr, 1'b1, S_DECODE, CW_DEC);
    ex({t, ".B"},  1'b0, OP_BEQ, 3'b000, 7'd0, zr, 1'b1, S_BEQ,
       {4'b0000, zr, 1'b0, 2'b10, 2'b00, 2'b00, 3'b001, 2'b00, 1'b1});
  endtask

  initial begin
    rst = 1'b1; op = 7'd0; funct3 = 3'd0; funct7 = 7'd0; zero = 1'b0; mem_ready = 1'b0;

    ex("por0", 1'b1, OP_LW, 3'd0, 7'd0, 1'b0, 1'b1, S_FETCH, CW_ZERO);
    ex("por1", 1'b1, OP_LW, 3'd0, 7'd0, 1'b0, 1'b1, S_FETCH, CW_ZERO);

    run_lw("lw");

    // sw with one fetch wait and two store waits
    ex("sw.Fw",  1'b0, OP_SW, 3'b010, 7'd0, 1'b0, 1'b0, S_FETCH,  CW_FETCH_W);
    ex("sw.F",   1'b0, OP_SW, 3'b010, 7'd0, 1'b0, 1'b1, S_FETCH,  CW_FETCH_R);
    ex("sw.D",   1'b0, OP_SW, 3'b010, 7'd0, 1'b0, 1'b1, S_DECODE, CW_DEC);
    ex("sw.MA",  1'b0, OP_SW, 3'b010, 7'd0, 1'b0, 1'b1, S_MEMADR, CW_ADR_SW);
    ex("sw.W0",  1'b0, OP_SW, 3'b010, 7'd0, 1'b0, 1'b0, S_MEMWR,  CW_WR_W);
    ex("sw.W1",  1'b0, OP_SW, 3'b010, 7'd0, 1'b0, 1'b0, S_MEMWR,  CW_WR_W);
    ex("sw.W2",  1'b0, OP_SW, 3'b010, 7'd0, 1'b0, 1'b1, S_MEMWR,  CW_WR_R);

    run_r("sub", 3'b000, 7'b0100000, 3'b001);
    run_r("or",  3'b110, 7'b0000000, 3'b011);
    run_r("xor", 3'b100, 7'b0000000, 3'b111);
    run_r("add", 3'b000, 7'b0000000, 3'b000);
    run_r("slt", 3'b010, 7'b0000000, 3'b101);
    run_r("and", 3'b111, 7'b0000000, 3'b010);

    run_beq("beqT", 1'b1);
    run_beq("beqN", 1'b0);

    ex("unk.F", 1'b0, 7'b0010011, 3'd0, 7'd0, 1'b0, 1'b1, S_FETCH, CW_FETCH_R);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    ex("unk.D", 1'b0, 7'b0010011, 3'd0, 7'd0, 1'b0, 1'b1, S_DECODE, CW_DEC);
    chk("unk.D.illegal", 32'(illegal), 32'd0);
    for (int i = 0; i < 3; i++) begin
      ex("trap", 1'b0, OP_LW, 3'd0, 7'd0, 1'b1, 1'b1, S_TRAP, CW_ZERO);
      chk("trap.illegal", 32'(illegal), 32'd1);
    end
    ex("trap.rst", 1'b1, OP_LW, 3'd0, 7'd0, 1'b0, 1'b1, S_FETCH, CW_ZERO);
    chk("trap.rst.illegal", 32'(illegal), 32'd0);
`else
    ex("unk.D", 1'b0, 7'b0010011, 3'd0, 7'd0, 1'b0, 1'b1, S_DECODE, CW_DEC_UNK);
`endif

    // Reset held three cycles in the middle of a load
    ex("mr.F",  1'b0, OP_LW, 3'b010, 7'd0, 1'b0, 1'b1, S_FETCH,  CW_FETCH_R);
    ex("mr.D",  1'b0, OP_LW, 3'b010, 7'd0, 1'b0, 1'b1, S_DECODE, CW_DEC);
    ex("mr.MA", 1'b0, OP_LW, 3'b010, 7'd0, 1'b0, 1'b1, S_MEMADR, CW_ADR_LW);
    ex("mr.MR", 1'b0, OP_LW, 3'b010, 7'd0, 1'b0, 1'b0, S_MEMRD,  CW_RD);
    for (int i = 0; i < 3; i++) begin
      ex("mr.rst", 1'b1, OP_LW, 3'b010, 7'd0, 1'b0, 1'b1, S_FETCH, CW_ZERO);
    end
    ex("mr.rel", 1'b0, OP_LW, 3'b010, 7'd0, 1'b0, 1'b0, S_FETCH, CW_FETCH_W);
    run_lw("lw2");
    ex("end.F", 1'b0, OP_LW, 3'b010, 7'd0, 1'b0, 1'b0, S_FETCH, CW_FETCH_W);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing controller for a multi-cycle build of the team's RV32 core (lw, sw, R-type add/sub/and/or/slt/xor, beq). It replaces the purely combinational single-cycle control with a Moore state machine. The datapath shares one ALU and one unified instruction/data memory, and this block drives them across FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK. It sits beside the datapath and drives all mux selects and write enables. It handshakes with memory through `mem_req`/`mem_ready`.

## Interface
Parameters:
- `STATE_W`, default 4: width of the `state_o` debug port.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `op`  in  7  opcode from the instruction register.
- `funct3`  in  3  funct3 from the instruction register.
- `funct7`  in  7  funct7 from the instruction register.
- `zero`  in  1  ALU Zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access request.
- `mem_write`  out  1  write strobe, qualified by `mem_req`.
- `adr_src`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  load IR and OldPC.
- `pc_write`  out  1  load PC from Result.
- `reg_write`  out  1  register-file write enable.
- `alu_src_a`  out  2  00 = PC, 01 = OldPC, 10 = rs1 register A.
- `alu_src_b`  out  2  00 = register B, 01 = ImmExt, 10 = constant 4.
- `imm_src`  out  2  00 = I-type, 01 = S-type, 10 = B-type.
- `alu_control`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 111 xor.
- `result_src`  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- `retire`  out  1  one-cycle pulse when an instruction completes.
- `state_o`  out  `STATE_W`  current state, for debug and fault injection.

## Operation
Opcodes: lw 0000011, sw 0100011, R 0110011, beq 1100011.

Unlisted outputs are 0 in every state.

- **FETCH**
  - Drives `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_control`=000, `result_src`=10.
  - `ir_write` and `pc_write` are high only in the cycle `mem_ready`=1; that cycle moves to DECODE. Otherwise it stays in FETCH.
- **DECODE**
  - Drives `alu_src_a`=01, `alu_src_b`=01, `imm_src`=10, `alu_control`=000 (branch target into ALUOut).
  - Next state: lw or sw → MEMADR; R → EXECR; beq → BEQ; any other opcode → FETCH (treated as NOP; PC is already +4).
  - An unknown opcode asserts `retire` in this cycle.
- **MEMADR**
  - Drives `alu_src_a`=10, `alu_src_b`=01, `alu_control`=000.
  - `imm_src` is 00 for lw and 01 for sw.
  - Next state: lw → MEMRD, sw → MEMWR.
- **MEMRD**
  - Drives `mem_req`=1, `adr_src`=1.
  - Waits for `mem_ready`, then moves to MEMWB.
- **MEMWB**
  - Drives `result_src`=01, `reg_write`=1, `retire`=1.
  - Next state: FETCH.
- **MEMWR**
  - Drives `mem_req`=1, `mem_write`=1, `adr_src`=1.
  - On `mem_ready` it asserts `retire` and moves to FETCH.
- **EXECR**
  - Drives `alu_src_a`=10, `alu_src_b`=00, and `alu_control` from the decoder.
  - Decoder, keyed on funct3: 000 → sub when {op[5],funct7[5]}=11, else add; 010 → slt; 110 → or; 111 → and; 100 → xor; otherwise add.
  - Next state: ALUWB.
- **ALUWB**
  - Drives `result_src`=00, `reg_write`=1, `retire`=1.
  - Next state: FETCH.
- **BEQ**
  - Drives `alu_src_a`=10, `alu_src_b`=00, `alu_control`=001, `result_src`=00, `retire`=1.
  - `pc_write` = `zero`.
  - Next state: FETCH.

## Timing
- Reset
  - While `rst`=1, every output is forced to 0, including `mem_req`.
  - The next state is FETCH, and `state_o` reads FETCH from the following cycle.
  - A reset asserted mid-instruction aborts it: no write strobe is issued in the reset cycle and no partial writeback occurs.
- Latency with `mem_ready` tied to 1:
  - lw 5 cycles, sw 4, R 4, beq 3, unknown opcode 2.
  - Each wait cycle (`mem_ready`=0 in FETCH, MEMRD or MEMWR) adds one cycle.
- Handshake
  - `mem_req` and `mem_write` stay stable until the cycle in which `mem_ready`=1.
  - `mem_ready` is ignored when `mem_req`=0.
- `op`, `funct3` and `funct7` are sampled only in DECODE, MEMADR and EXECR. The IR holds them stable after FETCH.
- Outputs are combinational from state, except:
  - `ir_write`, `pc_write`, `retire` in FETCH and MEMWR also depend on `mem_ready`;
  - `pc_write` in BEQ also depends on `zero`.

## Configuration
- `MULTICYCLE_ILLEGAL_TRAP_EN` defined:
  - An unknown opcode in DECODE moves to TRAP, with no `retire`.
  - TRAP holds every control output at 0 and sets a sticky `illegal` output port (1 bit, reset 0) to 1.
  - Only `rst` leaves TRAP.
- Not defined:
  - No TRAP state and no `illegal` port.
  - An unknown opcode takes the DECODE → FETCH NOP path.

## Structure
- Package `multicycle_pkg` holds:
  - the state enum (including TRAP);
  - opcode constants;
  - `alu_control` encodings;
  - `alu_src_a`/`alu_src_b`/`result_src`/`imm_src` select encodings.
- One sub-module, `mc_alu_op_decode`: a combinational map from (`funct3`, `funct7[5]`, `op[5]`) to `alu_control`, used only in EXECR.

## Test plan
- **Reset:** `rst` held high for 3 cycles during MEMRD → all outputs 0 in those cycles; `state_o`=FETCH in the first cycle after release; `mem_req`=1.
- **lw, zero wait:** `op`=0000011, `mem_ready`=1 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB; `reg_write`=1 with `result_src`=01 in cycle 5; one `retire`.
- **sw with 2 wait cycles:** `mem_ready`=0,0,1 in MEMWR → `mem_write`=1 held 3 cycles; return to FETCH; no `reg_write`.
- **R-type decode:** sub (`funct3`=000, `funct7`=0100000, `op`=0110011) → `alu_control`=001 in EXECR; or (`funct3`=110) → 011; xor (`funct3`=100) → 111.
- **beq:** `zero`=1 → `pc_write`=1 in BEQ with `result_src`=00; `zero`=0 → `pc_write`=0; both take 3 cycles.
- **Unknown opcode 0010011:**
  - Macro off: back to FETCH after 2 cycles, with `retire`.
  - Macro on: `illegal`=1, all controls 0, stays in TRAP until `rst`.
